// File: rtl/network_stream_harness.sv
// ============================================================================
// Module   : network_stream_harness
// Brief    : Stream source/sink for on-FPGA self-checking of network layers.
//            Streams NUMINPUTVALS words from an input memory into the network,
//            receives NUMOUTPUTVALS words and compares each against an
//            expected-value memory, and reports done, the error count and the
//            first failing index. Both memories load through a write port.
// Options  : NETWORK_HARNESS_THROTTLE_EN - LFSR-driven random backpressure on
//            the tx_valid assertion and on rx_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module network_stream_harness #(
    parameter int T             = 16,
    parameter int NUMINPUTVALS  = 10000,
    parameter int NUMOUTPUTVALS = 40000,
    parameter int CNTW          = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mem_we,
    input  logic                mem_sel,
    input  logic [CNTW-1:0]     mem_addr,
    input  logic [T-1:0]        mem_wdata,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [T-1:0]        tx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic signed [T-1:0] rx_data,
    output logic                busy,
    output logic                done,
    output logic [CNTW-1:0]     err_count,
    output logic [CNTW-1:0]     first_err_idx
);

    localparam int c_in_aw  = (NUMINPUTVALS  > 1) ? $clog2(NUMINPUTVALS)  : 1;
    localparam int c_out_aw = (NUMOUTPUTVALS > 1) ? $clog2(NUMOUTPUTVALS) : 1;
    localparam logic [CNTW-1:0] c_num_in  = CNTW'(NUMINPUTVALS);
    localparam logic [CNTW-1:0] c_num_out = CNTW'(NUMOUTPUTVALS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] j_q, j_d;
    logic [CNTW-1:0] i_q, i_d;
    logic [CNTW-1:0] err_count_q, err_count_d;
    logic [CNTW-1:0] first_err_idx_q, first_err_idx_d;
    logic            tx_valid_q, tx_valid_d;
    logic            rx_ready_q, rx_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [T-1:0]    in_mem  [NUMINPUTVALS];
    logic [T-1:0]    exp_mem [NUMOUTPUTVALS];

    logic            w_start_ok;
    logic            w_tx_hs;
    logic            w_rx_hs;
    logic [CNTW-1:0] w_j_inc;
    logic [CNTW-1:0] w_i_inc;
    logic            w_mismatch;
    logic            w_mem_wr;
    logic            w_gate_tx;
    logic            w_gate_rx;

    // start only counts outside RUN; a write colliding with it is dropped
    assign w_start_ok = start && (state_q != ST_RUN);
    assign w_mem_wr   = mem_we && !start && (state_q != ST_RUN);
    assign w_tx_hs    = tx_valid_q && tx_ready;
    assign w_rx_hs    = rx_valid && rx_ready_q;
    assign w_j_inc    = j_q + 1'b1;
    assign w_i_inc    = i_q + 1'b1;

    // rx_ready is only high while i < NUMOUTPUTVALS, so the index is in range
    assign w_mismatch = ($unsigned(rx_data) != exp_mem[i_q[c_out_aw-1:0]]);

    // Past the end of the input stream present zero rather than an invalid read
    assign tx_data = (j_q < c_num_in) ? in_mem[j_q[c_in_aw-1:0]] : '0;

`ifdef NETWORK_HARNESS_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, reseeded on every accepted start
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (w_start_ok) begin
            lfsr_d = 16'hACE1;
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_gate_tx = lfsr_q[0];
    assign w_gate_rx = lfsr_q[1];
`else
    assign w_gate_tx = 1'b1;
    assign w_gate_rx = 1'b1;
`endif

    // Next-state logic for the run FSM, both stream sides and the checker
    always_comb begin
        state_d         = state_q;
        j_d             = j_q;
        i_d             = i_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        tx_valid_d      = 1'b0;
        rx_ready_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d         = ST_RUN;
                    j_d             = '0;
                    i_d             = '0;
                    err_count_d     = '0;
                    first_err_idx_d = '1;
                end
            end

            ST_RUN: begin
                // Transmit: a raised tx_valid holds until it is accepted
                if (tx_valid_q) begin
                    if (tx_ready) begin
                        j_d        = w_j_inc;
                        tx_valid_d = (w_j_inc < c_num_in) && w_gate_tx;
                    end else begin
                        tx_valid_d = 1'b1;
                    end
                end else begin
                    tx_valid_d = (j_q < c_num_in) && w_gate_tx;
                end

                // Receive and check
                if (w_rx_hs) begin
                    i_d = w_i_inc;
                    if (w_mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (first_err_idx_q == '1) begin
                            first_err_idx_d = i_q;
                        end
                    end
                    if (w_i_inc >= c_num_out) begin
                        state_d    = ST_DONE;
                        tx_valid_d = 1'b0;
                        rx_ready_d = 1'b0;
                    end else begin
                        rx_ready_d = w_gate_rx;
                    end
                end else begin
                    rx_ready_d = (i_q < c_num_out) && w_gate_rx;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Control and status registers; memories are deliberately not reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            j_q             <= '0;
            i_q             <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '1;
            tx_valid_q      <= 1'b0;
            rx_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            j_q             <= j_d;
            i_q             <= i_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            tx_valid_q      <= tx_valid_d;
            rx_ready_q      <= rx_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    // Memory load port; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            if (!mem_sel) begin
                if (mem_addr < c_num_in) begin
                    in_mem[mem_addr[c_in_aw-1:0]] <= mem_wdata;
                end
            end else begin
                if (mem_addr < c_num_out) begin
                    exp_mem[mem_addr[c_out_aw-1:0]] <= mem_wdata;
                end
            end
        end
    end

    assign tx_valid      = tx_valid_q;
    assign rx_ready      = rx_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;

endmodule

`default_nettype wire

// File: doc/network_stream_harness.md
Name: network_stream_harness

Overview:
- Synthesizable stream source/sink that drives a network's slave input stream and consumes its master output stream, for on-FPGA self-checking of generated network_* layers.
- Transmitter side: streams NUMINPUTVALS words from an input memory.
- Receiver side: accepts NUMOUTPUTVALS words and compares each against an expected-value memory.
- Reports done, error count and first failing index; memories are loaded through a simple write port.

Parameters:
- T, 16, data word width (signed)
- NUMINPUTVALS, 10000, words to transmit
- NUMOUTPUTVALS, 40000, words to receive and check
- CNTW, 32, width of index and error counters

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a run from IDLE or DONE
- mem_we  in  1  memory write strobe
- mem_sel  in  1  0 = input memory, 1 = expected memory
- mem_addr  in  CNTW  write address
- mem_wdata  in  T  write data
- tx_valid  out  1  to network s_valid
- tx_ready  in  1  from network s_ready
- tx_data  out  T  to network data_in
- rx_valid  in  1  from network m_valid
- rx_ready  out  1  to network m_ready
- rx_data  in  T  from network data_out (signed)
- busy  out  1  high in RUN
- done  out  1  high in DONE
- err_count  out  CNTW  mismatch count, saturating at all-ones
- first_err_idx  out  CNTW  index i of the first mismatch; all-ones if none

Behaviour:
- Reset (reset=0, async) forces the following:
  - state IDLE; tx_valid=0, rx_ready=0, busy=0, done=0
  - err_count=0, first_err_idx=all-ones
  - tx index j=0, rx index i=0
  - memory contents are not cleared.
- FSM IDLE -> RUN on start:
  - same edge clears j, i, err_count and first_err_idx.
- FSM RUN -> DONE on the edge where the receive handshake takes i to NUMOUTPUTVALS.
- FSM DONE -> RUN on start, with the same clears as from IDLE.
- start is ignored in RUN.
- Transmit, RUN only:
  - tx_valid=1 while j<NUMINPUTVALS, subject to the throttle below.
  - tx_data = input_mem[j], combinational read.
  - Handshake is tx_valid&&tx_ready; j increments on that edge.
  - Once tx_valid is high it holds, with stable tx_data, until the handshake.
  - When j reaches NUMINPUTVALS, tx_valid drops the next cycle and stays low for the rest of the run.
- Receive, RUN only:
  - rx_ready=1 while i<NUMOUTPUTVALS.
  - On rx_valid&&rx_ready, compare rx_data against expected_mem[i] bitwise; any X/Z-free bit mismatch counts.
  - On mismatch: err_count+1 (saturating); first_err_idx<=i if it is still all-ones.
  - i increments on every handshake.
- Transmit and receive are independent; handshakes on both sides in the same cycle are both honoured.
- done stays high in DONE until start or reset; outputs received in DONE are not accepted (rx_ready=0).
- Memory writes:
  - Accepted in IDLE and DONE only; ignored in RUN.
  - Out-of-range mem_addr is ignored.
  - A write and a start on the same edge: the write is ignored, start wins.
- Reset asserted mid-run aborts immediately to the reset state; the network must be reset alongside.
- Output ports are registered except tx_data, which is the combinational memory read.

Optional Feature:
- Macro: NETWORK_HARNESS_THROTTLE_EN.
- With the macro:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset and on start) advances every clock.
  - Bit 0 gates a new tx_valid assertion; it may only suppress tx_valid when it is not already high.
  - Bit 1 gates rx_ready; rx_ready is registered from that bit each cycle.
  - Emulates random backpressure on both sides.
- Without the macro: no gating; tx_valid and rx_ready are asserted whenever their index conditions hold.

Test Plan:
- Loopback, NUMINPUTVALS=NUMOUTPUTVALS=4, tx wired to rx, input=expected={1,2,3,4}, start -> 4 transfers, done=1 after the 4th handshake, err_count=0, first_err_idx=FFFFFFFF.
- Same loopback, expected[2]=16'h0009 -> done=1, err_count=1, first_err_idx=2.
- Stalled sink: tx_ready=0 for 5 cycles with tx_valid=1 -> tx_valid and tx_data (=input[0]) stable all 5 cycles, j unchanged; transfer completes when tx_ready rises.
- Reset mid-run after 2 handshakes -> all outputs at reset values; a new start reruns from j=i=0 with memories intact.
- mem_we during RUN to expected[0] -> ignored, result unchanged; the same write in DONE followed by start -> new expected value used.
- Throttle build, loopback of 64 words, 20 mismatches injected -> err_count=20, first_err_idx equals the lowest injected index, no tx_valid drop without a handshake.
